// File: rtl/reg_read_stage.sv
// Register-read stage: physical register file with write-back ports and a one-entry output latch.
// Define RRS_BYPASS_EN to forward same-edge write-back data to accepted reads.
module reg_read_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PREGS  = 64,
    parameter int unsigned PREG_W = 6,
    parameter int unsigned ROB_W  = 6,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned NWB    = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FREEZE,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_is_mem,
    input  logic [ROB_W-1:0]       in_rob,
    input  logic [PREG_W-1:0]      in_src1,
    input  logic [PREG_W-1:0]      in_src2,
    input  logic [PREG_W-1:0]      in_dst,
    input  logic [DATA_W-1:0]      in_imm,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [NWB-1:0]         wb_en,
    input  logic [NWB*PREG_W-1:0]  wb_idx,
    input  logic [NWB*DATA_W-1:0]  wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_is_mem,
    output logic [ROB_W-1:0]       out_rob,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_imm,
    output logic [DATA_W-1:0]      out_opa,
    output logic [DATA_W-1:0]      out_opb,
    output logic [DATA_W-1:0]      out_destval,
    output logic [PREG_W-1:0]      out_src1,
    output logic [PREG_W-1:0]      out_src2,
    output logic [PREG_W-1:0]      out_dst
);

    logic [DATA_W-1:0] regs_q [PREGS];

    logic [PREG_W-1:0] wb_idx_a  [NWB];
    logic [DATA_W-1:0] wb_data_a [NWB];
    logic [NWB-1:0]    wb_ok;

    logic              valid_q,   valid_d;
    logic              is_mem_q,  is_mem_d;
    logic [ROB_W-1:0]  rob_q,     rob_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [DATA_W-1:0] opa_q,     opa_d;
    logic [DATA_W-1:0] opb_q,     opb_d;
    logic [DATA_W-1:0] destval_q, destval_d;
    logic [PREG_W-1:0] src1_q,    src1_d;
    logic [PREG_W-1:0] src2_q,    src2_d;
    logic [PREG_W-1:0] dst_q,     dst_d;

    logic accept_c;

    // Unpack write-back ports; out-of-range indices are treated as disabled
    always_comb begin
        for (int k = 0; k < NWB; k++) begin
            wb_idx_a[k]  = wb_idx[k*PREG_W +: PREG_W];
            wb_data_a[k] = wb_data[k*DATA_W +: DATA_W];
            wb_ok[k]     = wb_en[k] && (32'(wb_idx_a[k]) < PREGS);
        end
    end

    assign in_ready = !FREEZE && (!valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

    function automatic logic [DATA_W-1:0] read_reg(input logic [PREG_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (32'(idx) < PREGS) v = regs_q[idx];
`ifdef RRS_BYPASS_EN
        // Later ports override earlier ones, matching the write priority
        for (int k = 0; k < NWB; k++) begin
            if (wb_ok[k] && (wb_idx_a[k] == idx)) v = wb_data_a[k];
        end
`endif
        return v;
    endfunction

    // Register file; the highest-numbered port lands last and wins
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < PREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int k = 0; k < NWB; k++) begin
                if (wb_ok[k]) regs_q[wb_idx_a[k]] <= wb_data_a[k];
            end
        end
    end

    // Output latch next-state: load on accept, otherwise hold with operand refresh
    always_comb begin
        valid_d   = valid_q;
        is_mem_d  = is_mem_q;
        rob_d     = rob_q;
        ctrl_d    = ctrl_q;
        imm_d     = imm_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        destval_d = destval_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        dst_d     = dst_q;
        if (accept_c) begin
            valid_d   = 1'b1;
            is_mem_d  = in_is_mem;
            rob_d     = in_rob;
            ctrl_d    = in_ctrl;
            imm_d     = in_imm;
            opa_d     = read_reg(in_src1);
            opb_d     = in_is_mem ? '0 : read_reg(in_src2);
            destval_d = read_reg(in_dst);
            src1_d    = in_src1;
            src2_d    = in_src2;
            dst_d     = in_dst;
        end else begin
            if (!FREEZE && out_ready) valid_d = 1'b0;
            if (valid_q) begin
                for (int k = 0; k < NWB; k++) begin
                    if (wb_ok[k]) begin
                        if (wb_idx_a[k] == src1_q) opa_d = wb_data_a[k];
                        if (!is_mem_q && (wb_idx_a[k] == src2_q)) opb_d = wb_data_a[k];
                        if (wb_idx_a[k] == dst_q) destval_d = wb_data_a[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q   <= 1'b0;
            is_mem_q  <= 1'b0;
            rob_q     <= '0;
            ctrl_q    <= '0;
            imm_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            destval_q <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            dst_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            is_mem_q  <= is_mem_d;
            rob_q     <= rob_d;
            ctrl_q    <= ctrl_d;
            imm_q     <= imm_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            destval_q <= destval_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            dst_q     <= dst_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_is_mem  = is_mem_q;
    assign out_rob     = rob_q;
    assign out_ctrl    = ctrl_q;
    assign out_imm     = imm_q;
    assign out_opa     = opa_q;
    assign out_opb     = opb_q;
    assign out_destval = destval_q;
    assign out_src1    = src1_q;
    assign out_src2    = src2_q;
    assign out_dst     = dst_q;

endmodule
